// File: rtl/commit_unit_if.sv
// commit_unit_if: shared types plus the reorder-buffer/commit/store bus of the commit unit
package commit_unit_pkg;
    localparam int BUF_SIZE = 8;
    typedef logic [3:0] tag_t;
    typedef logic [2:0] index_t;
    typedef logic [5:0] spectag_t;
    typedef enum logic [1:0] {S_NOT_USED, S_ISSUED, S_EXECUTED} e_state_t;
    typedef enum logic [1:0] {ALU, BRANCH, LOAD, STORE} unit_t;
    typedef struct packed {
        e_state_t   e_state;
        tag_t       tag;
        unit_t      unit;
        logic [4:0] dest;
        logic [31:0] result;
        logic [31:0] vk;
        logic [1:0] rwmm;
        spectag_t   speculative_tag;
        spectag_t   specific_speculative_tag;
    } entry_t;
endpackage

interface commit_unit_if;
    import commit_unit_pkg::*;
    entry_t           entries_all [BUF_SIZE];
    logic             flush;
    tag_t             flush_tag;
    logic             mem_ready;
    logic [1:0]       is_committed;
    index_t [1:0]     commit_index;
    logic [1:0]       reg_we;
    logic [1:0][4:0]  reg_waddr;
    logic [1:0][31:0] reg_wdata;
    logic             mem_valid;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_data;
    logic [1:0]       mem_rwmm;
    spectag_t         spectag_release;
    logic [31:0]      retired_count;

    modport master (
        input  entries_all, flush, flush_tag, mem_ready,
        output is_committed, commit_index, reg_we, reg_waddr, reg_wdata,
               mem_valid, mem_addr, mem_data, mem_rwmm, spectag_release, retired_count
    );
    modport slave (
        output entries_all, flush, flush_tag, mem_ready,
        input  is_committed, commit_index, reg_we, reg_waddr, reg_wdata,
               mem_valid, mem_addr, mem_data, mem_rwmm, spectag_release, retired_count
    );
endinterface

// File: rtl/commit_unit.sv
// commit_unit: in-order two-wide retirement from the reorder buffer with a blocking store handshake
module commit_unit
    import commit_unit_pkg::*;
(
    input logic clk,
    input logic rst_n,
    commit_unit_if.master bus
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t     state, state_nx;
    tag_t       next_tag, tag_nx;
    index_t     store_idx;
    logic       skip_inc, skip_nx;
    logic [1:0] hit, rdy, ret;
    index_t     idx [2];
    logic       store_start;

    // Find the live entries carrying next_tag and next_tag+1; lowest index wins
    always_comb begin
        hit = '0;
        idx = '{default: '0};
        for (int i = BUF_SIZE - 1; i >= 0; i--) begin
            for (int s = 0; s < 2; s++) begin
                if (bus.entries_all[i].e_state != S_NOT_USED &&
                    bus.entries_all[i].tag == next_tag + 4'(s)) begin
                    hit[s] = 1'b1;
                    idx[s] = index_t'(i);
                end
            end
        end
    end

    // Slot readiness; slot1 may depend only on the branch retiring alongside it in slot0
    always_comb begin
        rdy[0] = hit[0] && bus.entries_all[idx[0]].e_state == S_EXECUTED &&
                 bus.entries_all[idx[0]].speculative_tag == '0;
        rdy[1] = hit[1] && bus.entries_all[idx[1]].e_state == S_EXECUTED &&
                 (bus.entries_all[idx[1]].speculative_tag &
                  ~bus.entries_all[idx[0]].specific_speculative_tag) == '0;
        store_start = state == IDLE && !bus.flush && rdy[0] && bus.entries_all[idx[0]].unit == STORE;
        ret[0] = !bus.flush && (state == WAIT ? bus.mem_ready
                                              : rdy[0] && bus.entries_all[idx[0]].unit != STORE);
        ret[1] = !bus.flush && state == IDLE && rdy[0] && rdy[1] &&
                 bus.entries_all[idx[0]].unit != STORE && bus.entries_all[idx[1]].unit != STORE;
    end

    // Commit, register-write and speculation-release outputs per slot
    always_comb begin
        bus.spectag_release = '0;
        for (int s = 0; s < 2; s++) begin
            bus.is_committed[s] = ret[s];
            bus.commit_index[s] = ret[s] ? (state == WAIT ? store_idx : idx[s]) : '0;
            bus.reg_we[s]       = ret[s] && state == IDLE && bus.entries_all[idx[s]].dest != '0 &&
                                  bus.entries_all[idx[s]].unit != BRANCH;
            bus.reg_waddr[s]    = bus.reg_we[s] ? bus.entries_all[idx[s]].dest : '0;
            bus.reg_wdata[s]    = bus.reg_we[s] ? bus.entries_all[idx[s]].result : '0;
            if (ret[s] && state == IDLE && bus.entries_all[idx[s]].unit == BRANCH)
                bus.spectag_release = bus.spectag_release | bus.entries_all[idx[s]].specific_speculative_tag;
        end
    end

    // Next tag pointer and store FSM; a flush seen while waiting already accounts for the store
    always_comb begin
        state_nx = state;
        tag_nx   = next_tag;
        skip_nx  = skip_inc;
        if (bus.flush) begin
            tag_nx  = bus.flush_tag;
            skip_nx = state == WAIT;
        end else if (state == WAIT) begin
            if (bus.mem_ready) begin
                state_nx = IDLE;
                tag_nx   = skip_inc ? next_tag : next_tag + 4'd1;
                skip_nx  = 1'b0;
            end
        end else if (store_start) begin
            state_nx = WAIT;
        end else begin
            tag_nx = next_tag + tag_t'(ret[0]) + tag_t'(ret[1]);
        end
    end

    // State, registered store request and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            next_tag          <= '0;
            skip_inc          <= 1'b0;
            store_idx         <= '0;
            bus.mem_valid     <= 1'b0;
            bus.mem_addr      <= '0;
            bus.mem_data      <= '0;
            bus.mem_rwmm      <= '0;
            bus.retired_count <= '0;
        end else begin
            state             <= state_nx;
            next_tag          <= tag_nx;
            skip_inc          <= skip_nx;
            bus.mem_valid     <= state_nx == WAIT;
            bus.retired_count <= bus.retired_count + 32'(ret[0]) + 32'(ret[1]);
            if (store_start) begin
                store_idx    <= idx[0];
                bus.mem_addr <= bus.entries_all[idx[0]].result;
                bus.mem_data <= bus.entries_all[idx[0]].vk;
                bus.mem_rwmm <= bus.entries_all[idx[0]].rwmm;
            end
        end
    end
endmodule

// File: doc/commit_unit.md
COMMIT_UNIT -- requirements
Module: commit_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n as elsewhere in the codebase.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 entries_all  in  entry_t[BUF_SIZE]  reorder buffer contents (same array dispatch reads).
REQ-005 flush  in  1  mispredict squash request.
REQ-006 flush_tag  in  tag_t  tag of the oldest surviving instruction after a flush.
REQ-007 mem_ready  in  1  memory accepts the store request.
REQ-008 is_committed  out  1[2]  slot retires this cycle; the buffer owner frees commit_index next edge.
REQ-009 commit_index  out  index_t[2]  buffer index of each retiring entry.
REQ-010 reg_we / reg_waddr / reg_wdata  out  1[2] / 5[2] / 32[2]  register-file write ports, one per slot.
REQ-011 mem_valid / mem_addr / mem_data / mem_rwmm  out  1 / 32 / 32 / width of entry_t.rwmm  registered store request.
REQ-012 spectag_release  out  spectag_t  OR of specific_speculative_tag of branches retiring this cycle.
REQ-013 retired_count  out  32  total instructions retired.

Function
REQ-014 SHALL hold next_tag (tag_t) naming the oldest unretired instruction; slot0 looks for tag next_tag and slot1 for next_tag+1, both modulo 16 (15 -> 0).
REQ-015 A slot SHALL be ready when the matching entry has e_state S_EXECUTED, and its speculative_tag is 0 (slot0) or speculative_tag & ~slot0.specific_speculative_tag is 0 (slot1).
REQ-016 Slot1 SHALL retire only when slot0 retires in the same cycle and neither slot is a STORE.
REQ-017 Non-store retire SHALL assert reg_we with waddr=Dest and wdata=result in the same cycle; reg_we=0 when Dest==0 or Unit==BRANCH.
REQ-018 The store FSM SHALL have the states IDLE and WAIT.
REQ-019 IDLE with a ready STORE in slot0: no retire that cycle; at the next edge latch index to store_idx, load mem_addr=result, mem_data=Vk, mem_rwmm=rwmm, set mem_valid=1 and go to WAIT.
REQ-020 WAIT: mem_* SHALL stay stable and no instruction other than the store may retire.
REQ-021 WAIT with mem_ready=1: is_committed[0]=1 with commit_index[0]=store_idx that cycle; at the next edge mem_valid=0, state IDLE, next_tag+1.
REQ-022 next_tag SHALL advance at the edge by the number of slots retired (0, 1 or 2).
REQ-023 retired_count SHALL advance by the same amount and wrap at 2^32.
REQ-024 Flush asserted: is_committed and reg_we SHALL be 0 that cycle, and next_tag SHALL load flush_tag at the edge.
REQ-025 Flush during WAIT SHALL NOT cancel the store, which is non-speculative; it completes per REQ-021, and next_tag = flush_tag at the flush edge takes precedence over the increment.
REQ-026 An empty buffer or an unready head SHALL produce no outputs and leave state unchanged.
REQ-027 All outputs other than mem_* and retired_count SHALL be combinational from current state and inputs.

Reset
REQ-028 On rst_n=0, asynchronously: next_tag=0, state=IDLE, mem_valid=0, mem_addr/mem_data/mem_rwmm=0, store_idx=0, retired_count=0; the combinational outputs are 0 while entries_all is all S_NOT_USED.
REQ-029 Reset asserted in WAIT SHALL drop mem_valid immediately; the store is abandoned.

Verification
REQ-030 Two executed ALU entries, tags 0/1, Dest 5/6, results 0xA/0xB -> both slots retire in one cycle with reg writes x5=0xA and x6=0xB; next_tag=2 and retired_count=2.
REQ-031 next_tag=15, executed tags 15 and 0 -> both retire and next_tag wraps to 1.
REQ-032 Store at head, result=0x100, Vk=0xDEAD, mem_ready held 0 for 3 cycles -> mem_valid high and stable for 4 cycles; retire happens only on the mem_ready cycle and mem_valid=0 the next cycle.
REQ-033 Branch at tag 3 with specific tag 000100, and tag 4 speculative_tag=000100 -> both retire and spectag_release=000100.
REQ-034 Flush with flush_tag=9 during WAIT, then mem_ready -> the store retires, next_tag=9, and no reg_we in the flush cycle.
REQ-035 rst_n pulsed low in WAIT -> mem_valid=0 with no clock edge, and next_tag=0, retired_count=0.
